// File: rtl/multdiv_ctrl_pkg.sv
// Shared types and constants for the multiply/divide sequencing controllers.
package multdiv_ctrl_pkg;

  localparam int unsigned DATA_W         = 32;
  localparam int unsigned MULT_STEPS_DEF = 16;
  localparam int unsigned DIV_STEPS_DEF  = 32;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MULT = 2'd1,
    DIV  = 2'd2,
    DONE = 2'd3
  } state_t;

endpackage

// File: rtl/multdiv_ctrl_if.sv
// Bundle between the multdiv controller, its requester and the external mult/div datapaths.
interface multdiv_ctrl_if;
  import multdiv_ctrl_pkg::*;

  logic              ctrl_MULT;
  logic              ctrl_DIV;
  logic [DATA_W-1:0] data_operandA;
  logic [DATA_W-1:0] data_operandB;
  logic [DATA_W-1:0] op_A;
  logic [DATA_W-1:0] op_B;
  logic [DATA_W-1:0] counter;
  logic [DATA_W-1:0] mult_product;
  logic              mult_overflow;
  logic [DATA_W-1:0] div_quotient;
  logic              div_exception;
  logic [DATA_W-1:0] data_result;
  logic              data_exception;
  logic              data_resultRDY;

  // Controller side
  modport slave (
    input  ctrl_MULT, ctrl_DIV, data_operandA, data_operandB,
    input  mult_product, mult_overflow, div_quotient, div_exception,
    output op_A, op_B, counter, data_result, data_exception, data_resultRDY
  );

  // Requester plus datapath side
  modport master (
    output ctrl_MULT, ctrl_DIV, data_operandA, data_operandB,
    output mult_product, mult_overflow, div_quotient, div_exception,
    input  op_A, op_B, counter, data_result, data_exception, data_resultRDY
  );

endinterface

// File: rtl/step_counter.sv
// Iteration counter with synchronous clear and enable; saturates at all-ones instead of wrapping.
module step_counter #(
  parameter int unsigned WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             clr,
  input  logic             en,
  output logic [WIDTH-1:0] count
);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      count <= '0;
    end else if (clr) begin
      count <= '0;
    end else if (en && (count != '1)) begin
      count <= count + WIDTH'(1);
    end
  end

endmodule

// File: rtl/multdiv_ctrl.sv
// Sequencing controller for iterative multiply/divide datapaths: latches operands,
// drives the step count and captures the datapath result after the final step.
module multdiv_ctrl
  import multdiv_ctrl_pkg::*;
#(
  parameter int unsigned MULT_STEPS = MULT_STEPS_DEF,
  parameter int unsigned DIV_STEPS  = DIV_STEPS_DEF
) (
  input  logic           clk,
  input  logic           reset_n,
  multdiv_ctrl_if.slave  bus
);

  localparam logic [DATA_W-1:0] MULT_LAST = DATA_W'(MULT_STEPS);
  localparam logic [DATA_W-1:0] DIV_LAST  = DATA_W'(DIV_STEPS);

  state_t state;

  logic start_c;
  logic mult_last_c;
  logic div_last_c;
  logic div_zero_c;
  logic cnt_en_c;

  // Step decode; a zero divisor exits once the load step (count 0) has been taken
  always_comb begin
    start_c     = 1'b0;
    mult_last_c = 1'b0;
    div_last_c  = 1'b0;
    div_zero_c  = 1'b0;
    cnt_en_c    = 1'b0;

    start_c     = bus.ctrl_MULT | bus.ctrl_DIV;
    mult_last_c = (state == MULT) && (bus.counter == MULT_LAST);
    div_last_c  = (state == DIV)  && (bus.counter == DIV_LAST);
    div_zero_c  = (state == DIV)  && (bus.op_B == '0) && (bus.counter != '0);
    cnt_en_c    = ((state == MULT) && !mult_last_c) ||
                  ((state == DIV)  && !div_last_c && !div_zero_c);
  end

  step_counter #(
    .WIDTH (DATA_W)
  ) u_step_counter (
    .clk     (clk),
    .reset_n (reset_n),
    .clr     (start_c),
    .en      (cnt_en_c),
    .count   (bus.counter)
  );

  // A strobe in any state restarts; multiply has priority over divide
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state              <= IDLE;
      bus.op_A           <= '0;
      bus.op_B           <= '0;
      bus.data_result    <= '0;
      bus.data_exception <= 1'b0;
      bus.data_resultRDY <= 1'b0;
    end else begin
      bus.data_resultRDY <= 1'b0;
      if (start_c) begin
        bus.op_A <= bus.data_operandA;
        bus.op_B <= bus.data_operandB;
        state    <= bus.ctrl_MULT ? MULT : DIV;
      end else begin
        case (state)
          IDLE: state <= IDLE;
          MULT: begin
            if (mult_last_c) begin
              bus.data_result    <= bus.mult_product;
              bus.data_exception <= bus.mult_overflow;
              bus.data_resultRDY <= 1'b1;
              state              <= DONE;
            end
          end
          DIV: begin
            if (div_zero_c) begin
              bus.data_result    <= '0;
              bus.data_exception <= 1'b1;
              bus.data_resultRDY <= 1'b1;
              state              <= DONE;
            end else if (div_last_c) begin
              bus.data_result    <= bus.div_quotient;
              bus.data_exception <= bus.div_exception;
              bus.data_resultRDY <= 1'b1;
              state              <= DONE;
            end
          end
          DONE:    state <= IDLE;
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_multdiv_ctrl.sv
// Directed bench for multdiv_ctrl with behavioural mult/div datapath models.
module tb_multdiv_ctrl;

  logic clk = 1'b0;
  logic reset_n;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  multdiv_ctrl_if bus ();

  multdiv_ctrl #(
    .MULT_STEPS (16),
    .DIV_STEPS  (32)
  ) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  // Datapath models fed from the latched operands
  longint prod;
  int     sa, sb;
  always_comb begin
    sa   = int'(bus.op_A);
    sb   = int'(bus.op_B);
    prod = longint'(sa) * longint'(sb);
    bus.mult_product  = prod[31:0];
    bus.mult_overflow = (prod != longint'(int'(prod[31:0])));
    bus.div_exception = (sb == 0);
    if (sb == 0 || (sb == -1 && sa == 32'sh80000000)) bus.div_quotient = 32'd0;
    else                                              bus.div_quotient = 32'(sa / sb);
  end

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, got, exp);
    end
  endtask

  // Strobe for one clock edge, driven one time unit after a rising edge
  task automatic strobe(input bit m, input bit d, input logic [31:0] a, input logic [31:0] b);
    bus.ctrl_MULT     = m;
    bus.ctrl_DIV      = d;
    bus.data_operandA = a;
    bus.data_operandB = b;
    @(posedge clk); #1;
    bus.ctrl_MULT     = 1'b0;
    bus.ctrl_DIV      = 1'b0;
    bus.data_operandA = 32'hDEAD_BEEF;
    bus.data_operandB = 32'hCAFE_F00D;
  endtask

  task automatic wait_rdy(output int lat);
    lat = -1;
    for (int i = 1; i <= 60; i++) begin
      @(posedge clk); #1;
      if (bus.data_resultRDY) begin
        lat = i;
        break;
      end
    end
  endtask

  task automatic wait_count(input logic [31:0] target, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 60; i++) begin
      if (bus.counter == target) begin
        ok = 1'b1;
        break;
      end
      @(posedge clk); #1;
    end
  endtask

  typedef struct {
    string       name;
    bit          m;
    bit          d;
    logic [31:0] a;
    logic [31:0] b;
    int          lat;
    logic [31:0] res;
    logic        exc;
  } vec_t;

  vec_t vecs[6];

  int lat;
  bit ok;
  int rdy_seen;

  initial begin
    vecs[0] = '{"mul_3x4",     1'b1, 1'b0, 32'd3,          32'd4, 17, 32'd12,         1'b0};
    vecs[1] = '{"mul_m7x6",    1'b1, 1'b0, 32'hFFFF_FFF9,  32'd6, 17, 32'hFFFF_FFD6,  1'b0};
    vecs[2] = '{"mul_ovf",     1'b1, 1'b0, 32'h4000_0000,  32'd4, 17, 32'd0,          1'b1};
    vecs[3] = '{"div_100_7",   1'b0, 1'b1, 32'd100,        32'd7, 33, 32'd14,         1'b0};
    vecs[4] = '{"div_by_zero", 1'b0, 1'b1, 32'd5,          32'd0,  2, 32'd0,          1'b1};
    vecs[5] = '{"mul_div_both",1'b1, 1'b1, 32'd6,          32'd3, 17, 32'd18,         1'b0};

    bus.ctrl_MULT     = 1'b0;
    bus.ctrl_DIV      = 1'b0;
    bus.data_operandA = 32'd0;
    bus.data_operandB = 32'd0;
    reset_n           = 1'b0;
    #1;
    check("rst_counter", bus.counter, 32'd0);
    check("rst_opA", bus.op_A, 32'd0);
    check("rst_opB", bus.op_B, 32'd0);
    check("rst_result", bus.data_result, 32'd0);
    check("rst_exc", 32'(bus.data_exception), 32'd0);
    check("rst_rdy", 32'(bus.data_resultRDY), 32'd0);
    @(negedge clk); reset_n = 1'b1;
    @(posedge clk); #1;

    foreach (vecs[i]) begin
      strobe(vecs[i].m, vecs[i].d, vecs[i].a, vecs[i].b);
      check({vecs[i].name, "_opA"}, bus.op_A, vecs[i].a);
      wait_rdy(lat);
      check({vecs[i].name, "_lat"}, 32'(lat), 32'(vecs[i].lat));
      check({vecs[i].name, "_res"}, bus.data_result, vecs[i].res);
      check({vecs[i].name, "_exc"}, 32'(bus.data_exception), 32'(vecs[i].exc));
      @(posedge clk); #1;
      check({vecs[i].name, "_pulse"}, 32'(bus.data_resultRDY), 32'd0);
      repeat (2) @(posedge clk);
      #1;
    end

    // Results and operands hold in IDLE while operand inputs wiggle
    bus.data_operandA = 32'h1234_5678;
    repeat (3) @(posedge clk);
    #1;
    check("hold_res", bus.data_result, 32'd18);
    check("hold_opA", bus.op_A, 32'd6);
    check("hold_cnt", bus.counter, 32'd16);

    // Restart an in-flight multiply
    strobe(1'b1, 1'b0, 32'd3, 32'd4);
    wait_count(32'd5, ok);
    check("restart_reach5", 32'(ok), 32'd1);
    strobe(1'b1, 1'b0, 32'd5, 32'd5);
    check("restart_cnt_clr", bus.counter, 32'd0);
    wait_rdy(lat);
    check("restart_lat", 32'(lat), 32'd17);
    check("restart_res", bus.data_result, 32'd25);
    repeat (2) @(posedge clk);
    #1;

    // Reset mid-operation
    strobe(1'b1, 1'b0, 32'd3, 32'd4);
    wait_count(32'd10, ok);
    check("rst_reach10", 32'(ok), 32'd1);
    reset_n = 1'b0;
    #1;
    check("midrst_counter", bus.counter, 32'd0);
    check("midrst_opA", bus.op_A, 32'd0);
    check("midrst_opB", bus.op_B, 32'd0);
    check("midrst_result", bus.data_result, 32'd0);
    check("midrst_rdy", 32'(bus.data_resultRDY), 32'd0);
    @(negedge clk); reset_n = 1'b1;
    rdy_seen = 0;
    for (int i = 0; i < 40; i++) begin
      @(posedge clk); #1;
      if (bus.data_resultRDY) rdy_seen++;
    end
    check("postrst_no_rdy", 32'(rdy_seen), 32'd0);
    check("postrst_counter", bus.counter, 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
